// File: rtl/alu_issue_if.sv
// Request/ALU/response bundle between an issuing stage and alu_issue.
interface alu_issue_if #(
   parameter int DATA_W = 32
);
   logic              req_valid;
   logic              req_ready;
   logic [5:0]        req_opcode;
   logic [5:0]        req_funct;
   logic [DATA_W-1:0] req_rs;
   logic [DATA_W-1:0] req_rt;
   logic [15:0]       req_imm;
   logic [3:0]        alu_op;
   logic [DATA_W-1:0] alu_a;
   logic [DATA_W-1:0] alu_b;
   logic [DATA_W-1:0] alu_result;
   logic              alu_zero;
   logic              rsp_valid;
   logic              rsp_ready;
   logic [DATA_W-1:0] rsp_result;
   logic              rsp_zero;
   logic [1:0]        rsp_err;

   // alu_issue side
   modport slave (
      input  req_valid, req_opcode, req_funct, req_rs, req_rt, req_imm,
      input  alu_result, alu_zero, rsp_ready,
      output req_ready, alu_op, alu_a, alu_b, rsp_valid, rsp_result,
      output rsp_zero, rsp_err
   );

   // Requester / ALU / consumer side
   modport master (
      output req_valid, req_opcode, req_funct, req_rs, req_rt, req_imm,
      output alu_result, alu_zero, rsp_ready,
      input  req_ready, alu_op, alu_a, alu_b, rsp_valid, rsp_result,
      input  rsp_zero, rsp_err
   );
endinterface

// File: rtl/alu_issue.sv
// Decodes a MIPS-style request, drives a registered ALU operation for one
// EXEC cycle and holds the captured result until the consumer takes it.
// Illegal encodings and divide-by-zero skip EXEC and respond with an error.
module alu_issue #(
   parameter int DATA_W = 32
) (
   input logic        clk,
   input logic        rst_n,
   alu_issue_if.slave bus
);

   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

   state_t            state_q, state_d;
   logic              req_ready_q, req_ready_d;
   logic              rsp_valid_q, rsp_valid_d;
   logic [3:0]        alu_op_q, alu_op_d;
   logic [DATA_W-1:0] alu_a_q, alu_a_d;
   logic [DATA_W-1:0] alu_b_q, alu_b_d;
   logic [DATA_W-1:0] rsp_result_q, rsp_result_d;
   logic              rsp_zero_q, rsp_zero_d;
   logic [1:0]        rsp_err_q, rsp_err_d;

   logic [3:0]        dec_op;
   logic [DATA_W-1:0] dec_b;
   logic              dec_legal;
   logic              dec_div;
   logic [DATA_W-1:0] imm_sext;
   logic [DATA_W-1:0] imm_zext;

   // Instruction decode: ALU op, operand B source and legality
   always_comb begin
      imm_sext  = {{(DATA_W-16){bus.req_imm[15]}}, bus.req_imm};
      imm_zext  = {{(DATA_W-16){1'b0}}, bus.req_imm};
      dec_op    = '0;
      dec_b     = bus.req_rt;
      dec_legal = 1'b1;
      dec_div   = 1'b0;
      case (bus.req_opcode)
         6'h00: begin
            case (bus.req_funct)
               6'h20:   dec_op = 4'b0010;
               6'h22:   dec_op = 4'b0110;
               6'h24:   dec_op = 4'b0000;
               6'h25:   dec_op = 4'b0001;
               6'h27:   dec_op = 4'b1100;
               6'h2A:   dec_op = 4'b0111;
               6'h18:   dec_op = 4'b1001;
               6'h1A: begin
                  dec_op  = 4'b1010;
                  dec_div = 1'b1;
               end
               default: dec_legal = 1'b0;
            endcase
         end
         6'h08, 6'h23, 6'h2B: begin
            dec_op = 4'b0010;
            dec_b  = imm_sext;
         end
         6'h04:   dec_op = 4'b0110;
         6'h0A: begin
            dec_op = 4'b0111;
            dec_b  = imm_sext;
         end
         6'h0C: begin
            dec_op = 4'b0000;
            dec_b  = imm_zext;
         end
         6'h0D: begin
            dec_op = 4'b0001;
            dec_b  = imm_zext;
         end
         default: dec_legal = 1'b0;
      endcase
   end

   // Next-state and next-output computation for the IDLE/EXEC/RESP sequence
   always_comb begin
      state_d      = state_q;
      alu_op_d     = alu_op_q;
      alu_a_d      = alu_a_q;
      alu_b_d      = alu_b_q;
      rsp_result_d = rsp_result_q;
      rsp_zero_d   = rsp_zero_q;
      rsp_err_d    = rsp_err_q;
      case (state_q)
         IDLE: begin
            if (bus.req_valid) begin
               if (!dec_legal) begin
                  state_d      = RESP;
                  rsp_result_d = '0;
                  rsp_zero_d   = 1'b0;
                  rsp_err_d    = 2'b01;
               end else if (dec_div && (dec_b == '0)) begin
                  state_d      = RESP;
                  rsp_result_d = '0;
                  rsp_zero_d   = 1'b0;
                  rsp_err_d    = 2'b10;
               end else begin
                  state_d  = EXEC;
                  alu_op_d = dec_op;
                  alu_a_d  = bus.req_rs;
                  alu_b_d  = dec_b;
               end
            end
         end
         EXEC: begin
            state_d      = RESP;
            rsp_result_d = bus.alu_result;
            rsp_zero_d   = bus.alu_zero;
            rsp_err_d    = 2'b00;
         end
         RESP: begin
            if (bus.rsp_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      req_ready_d = (state_d == IDLE);
      rsp_valid_d = (state_d == RESP);
   end

   // State and registered outputs, synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         req_ready_q  <= 1'b1;
         rsp_valid_q  <= 1'b0;
         alu_op_q     <= '0;
         alu_a_q      <= '0;
         alu_b_q      <= '0;
         rsp_result_q <= '0;
         rsp_zero_q   <= 1'b0;
         rsp_err_q    <= '0;
      end else begin
         state_q      <= state_d;
         req_ready_q  <= req_ready_d;
         rsp_valid_q  <= rsp_valid_d;
         alu_op_q     <= alu_op_d;
         alu_a_q      <= alu_a_d;
         alu_b_q      <= alu_b_d;
         rsp_result_q <= rsp_result_d;
         rsp_zero_q   <= rsp_zero_d;
         rsp_err_q    <= rsp_err_d;
      end
   end

   assign bus.req_ready  = req_ready_q;
   assign bus.rsp_valid  = rsp_valid_q;
   assign bus.alu_op     = alu_op_q;
   assign bus.alu_a      = alu_a_q;
   assign bus.alu_b      = alu_b_q;
   assign bus.rsp_result = rsp_result_q;
   assign bus.rsp_zero   = rsp_zero_q;
   assign bus.rsp_err    = rsp_err_q;

endmodule

// File: tb/tb_alu_issue.sv
// Bench for alu_issue: a vector table run through a scoreboard queue plus
// hand-written sequences for backpressure and mid-operation reset.
module tb_alu_issue;

   logic clk;
   logic rst_n;
   int   checks;
   int   errors;

   alu_issue_if #(.DATA_W(32)) bus ();

   alu_issue #(.DATA_W(32)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference ALU attached to the DUT's ALU port
   always_comb begin
      case (bus.alu_op)
         4'b0010: bus.alu_result = bus.alu_a + bus.alu_b;
         4'b0110: bus.alu_result = bus.alu_a - bus.alu_b;
         4'b0000: bus.alu_result = bus.alu_a & bus.alu_b;
         4'b0001: bus.alu_result = bus.alu_a | bus.alu_b;
         4'b1100: bus.alu_result = ~(bus.alu_a | bus.alu_b);
         4'b0111: bus.alu_result = ($signed(bus.alu_a) < $signed(bus.alu_b)) ? 32'd1 : 32'd0;
         4'b1001: bus.alu_result = bus.alu_a * bus.alu_b;
         4'b1010: bus.alu_result = (bus.alu_b != 32'd0) ? bus.alu_a / bus.alu_b : 32'd0;
         default: bus.alu_result = 32'hDEAD_BEEF;
      endcase
      bus.alu_zero = (bus.alu_result == 32'd0);
   end

   typedef struct {
      logic [5:0]  opcode;
      logic [5:0]  funct;
      logic [31:0] rs;
      logic [31:0] rt;
      logic [15:0] imm;
      logic [3:0]  op;
      logic [31:0] b;
      logic [31:0] res;
      logic        zero;
      logic [1:0]  err;
   } vec_t;

   localparam int NVEC = 18;
   vec_t vecs [NVEC];
   vec_t sb [$];

   task automatic chk(input string nm, input int idx, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s (case %0d): got %h expected %h", nm, idx, act, exp);
      end
   endtask

   // Wait for IDLE, perform one handshake, then scribble on the request inputs
   task automatic issue(input vec_t v, input int idx);
      int n;
      n = 0;
      while (bus.req_ready !== 1'b1 && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      chk("req_ready_before_issue", idx, {31'd0, bus.req_ready}, 32'd1);
      bus.req_opcode = v.opcode;
      bus.req_funct  = v.funct;
      bus.req_rs     = v.rs;
      bus.req_rt     = v.rt;
      bus.req_imm    = v.imm;
      bus.req_valid  = 1'b1;
      @(posedge clk); #1;
      sb.push_back(v);
      bus.req_opcode = 6'h00;
      bus.req_funct  = 6'h20;
      bus.req_rs     = $urandom;
      bus.req_rt     = $urandom;
      bus.req_imm    = 16'($urandom);
   endtask

   // Pop the oldest expectation and compare the held response against it
   task automatic check_rsp(input int idx);
      vec_t e;
      chk("rsp_valid", idx, {31'd0, bus.rsp_valid}, 32'd1);
      if (bus.rsp_valid === 1'b1 && sb.size() > 0) begin
         e = sb.pop_front();
         chk("rsp_result", idx, bus.rsp_result, e.res);
         chk("rsp_zero", idx, {31'd0, bus.rsp_zero}, {31'd0, e.zero});
         chk("rsp_err", idx, {30'd0, bus.rsp_err}, {30'd0, e.err});
      end
   endtask

   task automatic release_rsp(input int idx);
      bus.req_valid = 1'b0;
      bus.rsp_ready = 1'b1;
      @(posedge clk); #1;
      bus.rsp_ready = 1'b0;
      chk("rsp_valid_after_accept", idx, {31'd0, bus.rsp_valid}, 32'd0);
      chk("req_ready_after_accept", idx, {31'd0, bus.req_ready}, 32'd1);
   endtask

   task automatic check_reset_outputs(input int idx);
      chk("rst_rsp_valid", idx, {31'd0, bus.rsp_valid}, 32'd0);
      chk("rst_alu_op", idx, {28'd0, bus.alu_op}, 32'd0);
      chk("rst_alu_a", idx, bus.alu_a, 32'd0);
      chk("rst_alu_b", idx, bus.alu_b, 32'd0);
      chk("rst_rsp_result", idx, bus.rsp_result, 32'd0);
      chk("rst_rsp_zero", idx, {31'd0, bus.rsp_zero}, 32'd0);
      chk("rst_rsp_err", idx, {30'd0, bus.rsp_err}, 32'd0);
   endtask

   // Pulse reset for one edge, then confirm no stale response ever appears
   task automatic mid_reset(input int idx);
      int pulses;
      rst_n = 1'b0;
      bus.req_valid = 1'b0;
      @(posedge clk); #1;
      check_reset_outputs(idx);
      sb.delete();
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk("req_ready_after_release", idx, {31'd0, bus.req_ready}, 32'd1);
      pulses = 0;
      for (int unsigned i = 0; i < 4; i++) begin
         if (bus.rsp_valid !== 1'b0) pulses++;
         @(posedge clk); #1;
      end
      chk("no_rsp_after_reset", idx, pulses, 32'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      checks = 0;
      errors = 0;
      //           opc    fn     rs             rt             imm      op       b              res            z     err
      vecs[0]  = '{6'h00, 6'h20, 32'd5,         32'd7,         16'h0000, 4'b0010, 32'd7,         32'd12,        1'b0, 2'b00};
      vecs[1]  = '{6'h00, 6'h22, 32'd10,        32'd10,        16'h0000, 4'b0110, 32'd10,        32'd0,         1'b1, 2'b00};
      vecs[2]  = '{6'h00, 6'h24, 32'h0000_F0F0, 32'h0000_FF00, 16'h0000, 4'b0000, 32'h0000_FF00, 32'h0000_F000, 1'b0, 2'b00};
      vecs[3]  = '{6'h00, 6'h25, 32'h0000_00F0, 32'h0000_000F, 16'h0000, 4'b0001, 32'h0000_000F, 32'h0000_00FF, 1'b0, 2'b00};
      vecs[4]  = '{6'h00, 6'h27, 32'd0,         32'd0,         16'h0000, 4'b1100, 32'd0,         32'hFFFF_FFFF, 1'b0, 2'b00};
      vecs[5]  = '{6'h00, 6'h2A, 32'hFFFF_FFFF, 32'd1,         16'h0000, 4'b0111, 32'd1,         32'd1,         1'b0, 2'b00};
      vecs[6]  = '{6'h00, 6'h18, 32'd6,         32'd7,         16'h0000, 4'b1001, 32'd7,         32'd42,        1'b0, 2'b00};
      vecs[7]  = '{6'h00, 6'h1A, 32'd42,        32'd6,         16'h0000, 4'b1010, 32'd6,         32'd7,         1'b0, 2'b00};
      vecs[8]  = '{6'h00, 6'h1A, 32'd5,         32'd0,         16'h0000, 4'b0000, 32'd0,         32'd0,         1'b0, 2'b10};
      vecs[9]  = '{6'h00, 6'h21, 32'd5,         32'd7,         16'h0000, 4'b0000, 32'd0,         32'd0,         1'b0, 2'b01};
      vecs[10] = '{6'h04, 6'h00, 32'h0000_1234, 32'h0000_1234, 16'h0000, 4'b0110, 32'h0000_1234, 32'd0,         1'b1, 2'b00};
      vecs[11] = '{6'h08, 6'h00, 32'd1,         32'd99,        16'hFFFF, 4'b0010, 32'hFFFF_FFFF, 32'd0,         1'b1, 2'b00};
      vecs[12] = '{6'h0D, 6'h00, 32'd0,         32'd99,        16'hFFFF, 4'b0001, 32'h0000_FFFF, 32'h0000_FFFF, 1'b0, 2'b00};
      vecs[13] = '{6'h23, 6'h00, 32'h0000_0100, 32'd0,         16'h0004, 4'b0010, 32'd4,         32'h0000_0104, 1'b0, 2'b00};
      vecs[14] = '{6'h2B, 6'h00, 32'h0000_0100, 32'd0,         16'hFFFC, 4'b0010, 32'hFFFF_FFFC, 32'h0000_00FC, 1'b0, 2'b00};
      vecs[15] = '{6'h0A, 6'h00, 32'd5,         32'd0,         16'hFFFF, 4'b0111, 32'hFFFF_FFFF, 32'd0,         1'b1, 2'b00};
      vecs[16] = '{6'h0C, 6'h00, 32'hFFFF_FFFF, 32'd0,         16'h8000, 4'b0000, 32'h0000_8000, 32'h0000_8000, 1'b0, 2'b00};
      vecs[17] = '{6'h3F, 6'h00, 32'd1,         32'd2,         16'h0003, 4'b0000, 32'd0,         32'd0,         1'b0, 2'b01};

      rst_n          = 1'b0;
      bus.req_valid  = 1'b0;
      bus.req_opcode = '0;
      bus.req_funct  = '0;
      bus.req_rs     = '0;
      bus.req_rt     = '0;
      bus.req_imm    = '0;
      bus.rsp_ready  = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check_reset_outputs(-1);
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk("req_ready_after_reset", -1, {31'd0, bus.req_ready}, 32'd1);

      // Table sweep: one EXEC cycle for legal ops, straight to RESP on errors
      for (int unsigned i = 0; i < NVEC; i++) begin
         issue(vecs[i], int'(i));
         if (vecs[i].err == 2'b00) begin
            chk("exec_rsp_valid", int'(i), {31'd0, bus.rsp_valid}, 32'd0);
            chk("exec_req_ready", int'(i), {31'd0, bus.req_ready}, 32'd0);
            chk("alu_op", int'(i), {28'd0, bus.alu_op}, {28'd0, vecs[i].op});
            chk("alu_a", int'(i), bus.alu_a, vecs[i].rs);
            chk("alu_b", int'(i), bus.alu_b, vecs[i].b);
            @(posedge clk); #1;
         end
         check_rsp(int'(i));
         chk("resp_req_ready", int'(i), {31'd0, bus.req_ready}, 32'd0);
         release_rsp(int'(i));
      end

      // Backpressure: response must hold for five stalled cycles
      issue(vecs[0], 100);
      @(posedge clk); #1;
      for (int unsigned c = 0; c < 5; c++) begin
         chk("bp_rsp_valid", 100, {31'd0, bus.rsp_valid}, 32'd1);
         chk("bp_req_ready", 100, {31'd0, bus.req_ready}, 32'd0);
         chk("bp_rsp_result", 100, bus.rsp_result, 32'd12);
         chk("bp_rsp_err", 100, {30'd0, bus.rsp_err}, 32'd0);
         @(posedge clk); #1;
      end
      check_rsp(100);
      release_rsp(100);

      // Reset while a response is waiting
      issue(vecs[1], 200);
      @(posedge clk); #1;
      chk("pre_reset_rsp_valid", 200, {31'd0, bus.rsp_valid}, 32'd1);
      mid_reset(200);

      // Reset during EXEC
      issue(vecs[6], 300);
      chk("pre_reset_exec", 300, {31'd0, bus.rsp_valid}, 32'd0);
      mid_reset(300);

      // Block still works after the aborted operations
      issue(vecs[3], 400);
      @(posedge clk); #1;
      check_rsp(400);
      release_rsp(400);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/alu_issue.md
ALU_ISSUE -- requirements
Module: alu_issue

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, giving the operand and result width; only 32 is supported.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates occur on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1, a synchronous, active-low reset sampled on the rising edge of clk.
REQ-004 The block SHALL have port req_valid, input, 1, meaning a request is present.
REQ-005 The block SHALL have port req_ready, output, 1, meaning the block can accept a request.
REQ-006 The block SHALL have port req_opcode, input, 6, the instruction opcode field.
REQ-007 The block SHALL have port req_funct, input, 6, the R-type funct field.
REQ-008 The block SHALL have port req_rs, input, 32, the first operand.
REQ-009 The block SHALL have port req_rt, input, 32, the second register operand.
REQ-010 The block SHALL have port req_imm, input, 16, the immediate field.
REQ-011 The block SHALL have port alu_op, output, 4, the operation code driven to the ALU.
REQ-012 The block SHALL have port alu_a, output, 32, ALU operand A.
REQ-013 The block SHALL have port alu_b, output, 32, ALU operand B.
REQ-014 The block SHALL have port alu_result, input, 32, the combinational ALU result.
REQ-015 The block SHALL have port alu_zero, input, 1, the ALU zero flag.
REQ-016 The block SHALL have port rsp_valid, output, 1, meaning a response is present.
REQ-017 The block SHALL have port rsp_ready, input, 1, meaning the consumer accepts the response.
REQ-018 The block SHALL have port rsp_result, output, 32, the captured result.
REQ-019 The block SHALL have port rsp_zero, output, 1, the captured zero flag.
REQ-020 The block SHALL have port rsp_err, output, 2, the error code: 00 ok, 01 illegal, 10 divide-by-zero.

Function
REQ-021 The FSM SHALL have states IDLE, EXEC and RESP; req_ready SHALL be 1 only in IDLE, and rsp_valid SHALL be 1 only in RESP.
REQ-022 When req_valid and req_ready are both 1 in IDLE, the block SHALL register the decoded alu_op, alu_a and alu_b and move to EXEC on the next cycle.
REQ-023 R-type decoding (opcode 0x00) SHALL map funct as follows: 0x20 to 0010 add; 0x22 to 0110 sub; 0x24 to 0000 and; 0x25 to 0001 or; 0x27 to 1100 nor; 0x2A to 0111 slt; 0x18 to 1001 mul; 0x1A to 1010 div.
REQ-024 I-type decoding SHALL map opcodes as follows: 0x08, 0x23 and 0x2B to 0010; 0x04 to 0110; 0x0A to 0111; 0x0C to 0000; 0x0D to 0001.
REQ-025 alu_a SHALL equal req_rs, and alu_b SHALL be selected as follows:
- req_rt for R-type and for 0x04;
- sign-extended req_imm for 0x08, 0x0A, 0x23 and 0x2B;
- zero-extended req_imm for 0x0C and 0x0D.
REQ-026 On an unlisted opcode/funct pair, the block SHALL go from IDLE directly to RESP with rsp_err=01, rsp_result=0 and rsp_zero=0.
REQ-027 On a div request with alu_b==0, the block SHALL go directly to RESP with rsp_err=10, rsp_result=0 and rsp_zero=0; no EXEC cycle occurs.
REQ-028 EXEC SHALL last exactly one cycle; at its end the block SHALL capture alu_result into rsp_result and alu_zero into rsp_zero, set rsp_err=00, and move to RESP.
REQ-029 alu_op, alu_a and alu_b SHALL be registered and SHALL hold their last values outside EXEC.
REQ-030 In RESP, rsp_result, rsp_zero and rsp_err SHALL stay stable while rsp_ready is 0; when rsp_ready is 1 the block SHALL return to IDLE on the next cycle.
REQ-031 Latency SHALL be: request accepted at edge N gives rsp_valid=1 from edge N+2, or from N+1 on an error.
REQ-032 req_valid SHALL be ignored outside IDLE, and inputs other than rsp_ready SHALL not affect a response in flight.

Reset
REQ-033 While rst_n is 0 at a rising edge, the block SHALL enter IDLE and set alu_op=0000, alu_a=0, alu_b=0, rsp_valid=0, rsp_result=0, rsp_zero=0 and rsp_err=00; req_ready SHALL be 1 on the first cycle after rst_n returns to 1.
REQ-034 A reset asserted in EXEC or RESP SHALL abort the operation, drop the pending response, and produce no rsp_valid pulse afterwards.

Verification
REQ-035 The bench SHALL cover add: opcode 0x00, funct 0x20, rs=5, rt=7 -> alu_op=0010, rsp_result=12, zero=0, err=00 two cycles after acceptance.
REQ-036 The bench SHALL cover beq-equal: opcode 0x04, rs=rt=0x1234 -> alu_op=0110, rsp_result=0, rsp_zero=1.
REQ-037 The bench SHALL cover sign versus zero extension:
- addi with imm=0xFFFF -> alu_b=0xFFFFFFFF;
- ori with imm=0xFFFF -> alu_b=0x0000FFFF.
REQ-038 The bench SHALL cover div by zero: funct 0x1A, rt=0 -> rsp_valid one cycle after acceptance, err=10, result=0, and no EXEC.
REQ-039 The bench SHALL cover backpressure: rsp_ready held 0 for 5 cycles -> rsp_* stable and req_ready=0 throughout; rsp_ready=1 -> IDLE next cycle.
REQ-040 The bench SHALL cover reset in RESP: rst_n=0 one cycle -> rsp_valid=0, all outputs at reset values, and req_ready=1 after release.
